// File: rtl/ether_pkg.sv
// Shared types, CRC-32 constants and line-symbol helpers for the Ethernet
// receive path.
package ether_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // n/2 copies of 2'b01, right-aligned in a byte
  function automatic logic [7:0] pre_sym(input int unsigned n);
    logic [15:0] mask;
    mask = (16'h1 << n) - 16'h1;
    return 8'h55 & 8'(mask);
  endfunction

  // Preamble pattern with the top bit set: 11 / 1101 / 11010101
  function automatic logic [7:0] sfd_sym(input int unsigned n);
    logic [15:0] top;
    top = 16'h1 << (n - 1);
    return pre_sym(n) | 8'(top);
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 step: advances a CRC state by one byte,
// least significant bit first.
module crc32_byte
  import ether_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/ether_rx_framer.sv
// RMII-style receive framer: validates preamble/SFD, packs N-bit symbols into
// bytes, checks the trailing FCS and reports per-frame status.
module ether_rx_framer
  import ether_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned PRE_MIN   = 7,
  parameter int unsigned MAX_BYTES = 1522
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] rxd,
  input  logic         crsdv,
  output logic         axiov,
  output logic [7:0]   axiod,
  output logic         frame_done,
  output logic         crc_ok,
  output logic         err_align,
  output logic         err_len
);

  localparam int unsigned SPB = 8 / N;
  localparam int unsigned BCW = $clog2(MAX_BYTES + 1);
  localparam logic [N-1:0] PRE_SYM = N'(pre_sym(N));
  localparam logic [N-1:0] SFD_SYM = N'(sfd_sym(N));

  rx_state_t      state, state_n;
  logic [7:0]     pre_cnt, pre_cnt_n;
  logic [1:0]     sym_cnt, sym_cnt_n;
  logic [BCW-1:0] byte_cnt, byte_cnt_n;
  logic [7:0]     shreg, shreg_n;
  logic [31:0]    crc, crc_n, crc_upd;
  logic           axiov_n, frame_done_n, crc_ok_n, err_align_n, err_len_n;
  logic [7:0]     axiod_n;
  logic [7:0]     byte_c;
  logic           byte_done_c;

  // New symbols enter at the top so the first symbol of a byte ends up in the LSBs
  assign byte_c      = (shreg >> N) | (8'(rxd) << (8 - N));
  assign byte_done_c = (sym_cnt == 2'(SPB - 1));

  crc32_byte u_crc (
    .crc_in  (crc),
    .data    (byte_c),
    .crc_out (crc_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      sym_cnt    <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      crc        <= '0;
      axiov      <= 1'b0;
      axiod      <= '0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      err_align  <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state      <= state_n;
      pre_cnt    <= pre_cnt_n;
      sym_cnt    <= sym_cnt_n;
      byte_cnt   <= byte_cnt_n;
      shreg      <= shreg_n;
      crc        <= crc_n;
      axiov      <= axiov_n;
      axiod      <= axiod_n;
      frame_done <= frame_done_n;
      crc_ok     <= crc_ok_n;
      err_align  <= err_align_n;
      err_len    <= err_len_n;
    end
  end

  always_comb begin
    state_n      = state;
    pre_cnt_n    = pre_cnt;
    sym_cnt_n    = sym_cnt;
    byte_cnt_n   = byte_cnt;
    shreg_n      = shreg;
    crc_n        = crc;
    axiov_n      = 1'b0;
    axiod_n      = axiod;
    frame_done_n = 1'b0;
    crc_ok_n     = 1'b0;
    err_align_n  = 1'b0;
    err_len_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (crsdv) begin
          if (rxd == PRE_SYM) begin
            state_n   = PREAMBLE;
            pre_cnt_n = 8'd1;
          end else begin
            state_n = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!crsdv) begin
          state_n = IDLE;
        end else if (rxd == PRE_SYM) begin
          if (pre_cnt != 8'hFF) pre_cnt_n = pre_cnt + 8'd1;
        end else if (rxd == SFD_SYM && pre_cnt >= 8'(PRE_MIN)) begin
          state_n    = DATA;
          sym_cnt_n  = '0;
          byte_cnt_n = '0;
          crc_n      = CRC_INIT;
        end else begin
          state_n = DROP;
        end
      end
      DATA: begin
        if (crsdv) begin
          shreg_n = byte_c;
          if (byte_done_c) begin
            sym_cnt_n = '0;
            // One byte past the limit ends the frame without emitting that byte
            if (byte_cnt == BCW'(MAX_BYTES)) begin
              frame_done_n = 1'b1;
              err_len_n    = 1'b1;
              state_n      = DROP;
            end else begin
              axiov_n    = 1'b1;
              axiod_n    = byte_c;
              crc_n      = crc_upd;
              byte_cnt_n = byte_cnt + BCW'(1);
            end
          end else begin
            sym_cnt_n = sym_cnt + 2'd1;
          end
        end else begin
          frame_done_n = 1'b1;
          crc_ok_n     = (crc == CRC_RESIDUE) && (sym_cnt == 2'd0);
          err_align_n  = (sym_cnt != 2'd0);
          state_n      = IDLE;
        end
      end
      DROP: begin
        if (!crsdv) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/ether_rx_framer.md
Name: ether_rx_framer

Overview:
Parametrised successor to the RMII-style `ether` receiver. It accepts N-bit symbols per clock while `crsdv` is high and validates the preamble and SFD. It then assembles payload symbols into bytes, which it streams on an AXI-like valid/data interface. It checks the trailing CRC-32 and reports per-frame status (CRC ok, alignment error, length overflow) in the cycle after the frame ends. It sits between the PHY pins and the packet-parsing logic.

Parameters:
N, 4, symbol width in bits; legal values 2, 4, 8.
PRE_MIN, 7, minimum consecutive preamble symbols required before SFD; legal range 1 to 255.
MAX_BYTES, 1522, maximum bytes per frame, FCS included.

Ports:
clk  in  1  system clock; one symbol per cycle.
rst  in  1  synchronous, active-high reset.
rxd  in  N  received symbol, valid when crsdv=1.
crsdv  in  1  carrier sense / data valid.
axiov  out  1  one-cycle pulse; axiod holds a completed byte.
axiod  out  8  assembled byte.
frame_done  out  1  one-cycle pulse; the status outputs below are valid.
crc_ok  out  1  CRC residue matched; meaningful only with frame_done.
err_align  out  1  frame ended on a partial byte.
err_len  out  1  byte count exceeded MAX_BYTES.

Behaviour:
- Symbol constants:
  - PRE_SYM = N/2 copies of 2'b01.
  - SFD_SYM = {2'b11, (N-2)/2 copies of 2'b01}, i.e. 11 / 1101 / 11010101 for N = 2 / 4 / 8.
- Reset: state IDLE, all counters and CRC cleared, all outputs 0. Reset mid-frame abandons the frame and emits no frame_done.
- Inputs are sampled only on cycles with crsdv=1.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - crsdv=1 and rxd==PRE_SYM -> PREAMBLE, pre_cnt=1.
  - crsdv=1 and any other rxd -> DROP.
- PREAMBLE:
  - rxd==PRE_SYM -> pre_cnt++ (saturates at 255).
  - rxd==SFD_SYM and pre_cnt>=PRE_MIN -> DATA; clear sym_cnt, byte_cnt; crc=32'hFFFFFFFF.
  - rxd==SFD_SYM and pre_cnt<PRE_MIN -> DROP.
  - Any other rxd -> DROP.
  - crsdv=0 -> IDLE; no frame_done.
- DATA, crsdv=1:
  - Shift the symbol into the byte register, LSB first: the first symbol of a byte occupies bits [N-1:0].
  - When 8/N symbols are collected:
    - Register axiov=1 and axiod=byte on the next cycle (latency of 1 cycle from the last symbol of the byte).
    - Update crc with that byte; increment byte_cnt.
  - If byte_cnt would exceed MAX_BYTES:
    - Do not emit the byte.
    - Pulse frame_done with err_len=1, crc_ok=0, err_align=0.
    - Go to DROP.
- DATA, crsdv=0: next cycle, pulse frame_done with:
  - crc_ok = (crc == 32'hDEBB20E3) and no partial byte.
  - err_align = (sym_cnt mod (8/N) != 0); the partial byte is discarded.
  - err_len = 0.
  - Then IDLE.
- DROP: ignore rxd; crsdv=0 -> IDLE; no frame_done.
- CRC:
  - Reflected CRC-32, polynomial 32'hEDB88320, init all-ones, no final inversion internally.
  - Run over payload plus FCS; a correct frame leaves residue 32'hDEBB20E3.
- Zero-byte frame (SFD immediately followed by crsdv=0): frame_done with crc_ok=0 and err_align=0.
- crsdv may rise on the cycle immediately after frame_done; that cycle is handled as IDLE.
- axiov and frame_done are never asserted in the same cycle. The last byte's axiov precedes frame_done by at least 1 cycle.

Decomposition:
- Package ether_pkg holds:
  - the state enum `rx_state_t`;
  - localparams CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3;
  - functions `pre_sym(N)` and `sfd_sym(N)`.
- Sub-module `crc32_byte`: purely combinational next-CRC of a 32-bit state plus one byte. It is reusable by a future transmitter.

Test Plan:
All scenarios use N=4, PRE_MIN=7 unless stated. Bytes are driven low nibble first.
1. Good frame: 15×0101, 1101, payload "123456789" (0x31..0x39), FCS 26 39 F4 CB, then crsdv=0 -> 13 axiov pulses (0x31..0x39, 0x26, 0x39, 0xF4, 0xCB), then frame_done=1, crc_ok=1, err_align=0, err_len=0.
2. Same frame with payload 0x35 changed to 0x34 -> 13 axiov pulses with 0x34 in place, then frame_done with crc_ok=0.
3. Goofed preamble (13×0101, 0000, 1101, data) -> no axiov and no frame_done. The following good frame from scenario 1 passes with crc_ok=1.
4. Goofed SFD (15×0101, 1010, data) -> no axiov and no frame_done. Short preamble (5×0101, 1101) -> no output.
5. Scenario 1 plus one extra nibble 0x7 before crsdv=0 -> 13 axiov pulses, then frame_done with err_align=1, crc_ok=0.
6. MAX_BYTES=16 with a 20-byte payload -> 16 axiov pulses, frame_done with err_len=1 on the 17th byte, then silence. Separately, rst=1 after 3 payload bytes -> all outputs 0 and no frame_done.
